// File: rtl/vga_scan_engine_if.sv
// Bundle between the VGA scan engine and its frame buffer, colour config and (optional) IRQ logic.
// FRAME_IRQ/IRQ_ACK exist only when VGA_FRAME_IRQ_EN is defined.
interface vga_scan_engine_if;
  logic [15:0] config_col;
  logic [14:0] buf_addr;
  logic        buf_data;
  logic        hs;
  logic        vs;
  logic        vblank;
  logic [7:0]  colour_out;
`ifdef VGA_FRAME_IRQ_EN
  logic        frame_irq;
  logic        irq_ack;

  modport master (
    input  config_col, buf_data, irq_ack,
    output buf_addr, hs, vs, vblank, colour_out, frame_irq
  );
  modport slave (
    output config_col, buf_data, irq_ack,
    input  buf_addr, hs, vs, vblank, colour_out, frame_irq
  );
`else
  modport master (
    input  config_col, buf_data,
    output buf_addr, hs, vs, vblank, colour_out
  );
  modport slave (
    output config_col, buf_data,
    input  buf_addr, hs, vs, vblank, colour_out
  );
`endif
endinterface

// File: rtl/vga_scan_engine.sv
// 640x480@60 raster timing + 1bpp frame buffer colouring on CLK with a pixel enable; optional frame IRQ (VGA_FRAME_IRQ_EN).
// Outputs lag the counters by one pixel period; free-running, never stalls, no backpressure.
module vga_scan_engine #(
  parameter int PIX_DIV = 4,
  parameter int H_VIS   = 640,
  parameter int H_FP    = 16,
  parameter int H_SP    = 96,
  parameter int H_BP    = 48,
  parameter int V_VIS   = 480,
  parameter int V_FP    = 10,
  parameter int V_SP    = 2,
  parameter int V_BP    = 33
) (
  input  logic              CLK,
  input  logic              RESET,
  vga_scan_engine_if.master vga
);
  localparam int H_TOTAL = H_VIS + H_FP + H_SP + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SP + V_BP;
  localparam int DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PIX_DIV - 1);
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_L = 10'(H_VIS);
  localparam logic [9:0] V_VIS_L = 10'(V_VIS);
  localparam logic [9:0] HS_BEG  = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END  = 10'(H_VIS + H_FP + H_SP);
  localparam logic [9:0] VS_BEG  = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END  = 10'(V_VIS + V_FP + V_SP);

  logic [DIV_W-1:0] div;
  logic [9:0]       h_cnt;
  logic [9:0]       v_cnt;
  logic             pix_en;
  logic             in_vis;
  logic             hs_q;
  logic             vs_q;
  logic             vblank_q;
  logic [7:0]       colour_q;

  assign pix_en = (div == DIV_LAST);
  assign in_vis = (h_cnt < H_VIS_L) && (v_cnt < V_VIS_L);

  // 4x4 pixel blocks: the buffer address is just the counters with the low two bits dropped
  assign vga.buf_addr = {v_cnt[8:2], h_cnt[9:2]};

  always_ff @(posedge CLK) begin
    if (RESET) begin
      div      <= '0;
      h_cnt    <= '0;
      v_cnt    <= '0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      vblank_q <= 1'b0;
      colour_q <= 8'h00;
    end else if (pix_en) begin
      div <= '0;
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
      // Registered from the pre-advance position so sync and colour stay aligned
      hs_q     <= ~((h_cnt >= HS_BEG) && (h_cnt < HS_END));
      vs_q     <= ~((v_cnt >= VS_BEG) && (v_cnt < VS_END));
      vblank_q <= (v_cnt >= V_VIS_L);
      colour_q <= in_vis ? (vga.buf_data ? vga.config_col[15:8] : vga.config_col[7:0]) : 8'h00;
    end else begin
      div <= div + 1'b1;
    end
  end

  assign vga.hs         = hs_q;
  assign vga.vs         = vs_q;
  assign vga.vblank     = vblank_q;
  assign vga.colour_out = colour_q;

`ifdef VGA_FRAME_IRQ_EN
  logic irq_q;
  logic irq_set;

  assign irq_set = pix_en && (h_cnt == 10'd0) && (v_cnt == V_VIS_L);

  // Set has priority over a coincident acknowledge
  always_ff @(posedge CLK) begin
    if (RESET) begin
      irq_q <= 1'b0;
    end else if (irq_set) begin
      irq_q <= 1'b1;
    end else if (vga.irq_ack) begin
      irq_q <= 1'b0;
    end
  end

  assign vga.frame_irq = irq_q;
`endif
endmodule

// File: tb/tb_vga_scan_engine.sv
// Scoreboard bench for vga_scan_engine: default horizontal timing, shortened vertical timing so several frames fit.
module tb_vga_scan_engine;
  localparam int PD    = 4;
  localparam int H_VIS = 640, H_FP = 16, H_SP = 96, H_BP = 48;
  localparam int V_VIS = 6,   V_FP = 1,  V_SP = 2,  V_BP = 1;
  localparam int HT    = H_VIS + H_FP + H_SP + H_BP;
  localparam int VT    = V_VIS + V_FP + V_SP + V_BP;
  localparam int FRAME = HT * VT;

  typedef struct {
    int hs;
    int vs;
    int vblank;
    int col;
  } exp_t;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  int   edges = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mem [32768];
  exp_t q [$];

  vga_scan_engine_if bus ();

  vga_scan_engine #(
    .PIX_DIV(PD), .H_VIS(H_VIS), .H_FP(H_FP), .H_SP(H_SP), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SP(V_SP), .V_BP(V_BP)
  ) dut (
    .CLK  (CLK),
    .RESET(RESET),
    .vga  (bus)
  );

  always #5 CLK = ~CLK;

  // Edge count since reset release; pixel n's outputs appear on edge 4n+4
  always @(posedge CLK) edges <= RESET ? 0 : edges + 1;

  // Synchronous frame buffer read port
  always @(posedge CLK) bus.buf_data <= mem[bus.buf_addr];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, edges);
    end
  endtask

`ifdef VGA_FRAME_IRQ_EN
  bit exp_irq = 1'b0;
  always @(posedge CLK) begin
    if (RESET) exp_irq <= 1'b0;
    else if (edges % PD == PD - 1 && (edges / PD) % HT == 0 && ((edges / PD) / HT) % VT == V_VIS)
      exp_irq <= 1'b1;
    else if (bus.irq_ack) exp_irq <= 1'b0;
  end
`endif

  // Reference model: expected outputs for the pixel whose enable edge comes next
  always @(negedge CLK) begin
    if (!RESET && edges % PD == PD - 1) begin : model
      exp_t e;
      int n, h, v, a;
      n = edges / PD;
      h = n % HT;
      v = (n / HT) % VT;
      a = (v / 4) * 256 + (h / 4);
      e.hs     = (h >= H_VIS + H_FP && h < H_VIS + H_FP + H_SP) ? 0 : 1;
      e.vs     = (v >= V_VIS + V_FP && v < V_VIS + V_FP + V_SP) ? 0 : 1;
      e.vblank = (v >= V_VIS) ? 1 : 0;
      if (h < H_VIS && v < V_VIS)
        e.col = mem[a] ? int'(bus.config_col[15:8]) : int'(bus.config_col[7:0]);
      else
        e.col = 0;
      q.push_back(e);
    end
  end

  // Monitor: compare each registered pixel output and the live read address
  always @(negedge CLK) begin
    if (RESET) begin
      q.delete();
    end else begin : mon
      exp_t e;
      int n, h, v;
      n = edges / PD;
      h = n % HT;
      v = (n / HT) % VT;
      if (h < H_VIS && v < V_VIS) check("buf_addr", int'(bus.buf_addr), (v / 4) * 256 + (h / 4));
      if (edges > 0 && edges % PD == 0) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard: no expected entry at edge %0d", edges);
        end else begin
          e = q.pop_front();
          check("hs", int'(bus.hs), e.hs);
          check("vs", int'(bus.vs), e.vs);
          check("vblank", int'(bus.vblank), e.vblank);
          check("colour_out", int'(bus.colour_out), e.col);
        end
      end
`ifdef VGA_FRAME_IRQ_EN
      check("frame_irq", int'(bus.frame_irq), int'(exp_irq));
`endif
    end
  end

  // Called at posedge+1; holds RESET through one edge, optionally refilling the frame buffer
  task automatic pulse_reset(input int mem_mode);
    RESET = 1'b1;
    for (int i = 0; i < 32768; i++)
      mem[i] = (mem_mode == 0) ? bit'($urandom_range(0, 1)) : (mem_mode == 1) ? (i == 258) : 1'b1;
    @(posedge CLK); #1;
    RESET = 1'b0;
    check("rst_hs", int'(bus.hs), 1);
    check("rst_vs", int'(bus.vs), 1);
    check("rst_vblank", int'(bus.vblank), 0);
    check("rst_colour", int'(bus.colour_out), 0);
    check("rst_addr", int'(bus.buf_addr), 0);
`ifdef VGA_FRAME_IRQ_EN
    check("rst_irq", int'(bus.frame_irq), 0);
`endif
  endtask

  // Free-run until the counters sit on pixel n_target (one edge into that pixel)
  task automatic run_until(input int n_target, input int cfg_mode);
    int guard = 0;
    while (!(edges % PD == 1 && edges / PD == n_target) && guard < 70000) begin
      @(posedge CLK); #1;
      guard++;
      if (cfg_mode == 1 && $urandom_range(0, 49) == 0) bus.config_col = 16'($urandom);
      if (cfg_mode == 2 && $urandom_range(0, 6) == 0)
        bus.config_col = (bus.config_col == 16'hFF00) ? 16'h00FF : 16'hFF00;
`ifdef VGA_FRAME_IRQ_EN
      bus.irq_ack = 1'b0;
      // Clear after the flag has held across a frame boundary, then ack exactly on the next set cycle
      if (cfg_mode == 1 && edges == (FRAME + 100) * PD + 1) bus.irq_ack = 1'b1;
      if (cfg_mode == 1 && edges % PD == PD - 1 && edges / PD == FRAME + V_VIS * HT) bus.irq_ack = 1'b1;
`endif
    end
    checks++;
    if (guard >= 70000) begin
      errors++;
      $display("FAIL run_until: pixel %0d not reached, edge %0d", n_target, edges);
    end
  endtask

  initial begin
    bus.config_col = 16'($urandom);
`ifdef VGA_FRAME_IRQ_EN
    bus.irq_ack = 1'b0;
`endif
    @(posedge CLK); #1;
    pulse_reset(0);
    // Random image and colours through a full frame into the second frame's sync lines
    run_until(FRAME + (V_VIS + V_FP) * HT + 700, 1);
    // Mid-line reset with HS, VS and VBLANK all active; switch to the single-block pattern
    bus.config_col = 16'hE01F;
    pulse_reset(1);
    run_until(4 * HT + 300, 0);
    // Mid-line reset in the visible area; all-ones buffer with colour toggling between pixels
    bus.config_col = 16'hFF00;
    pulse_reset(2);
    run_until(500, 2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
